// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, field positions and exception codes for the
// interrupt controller slice.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/int_sync.sv
// One interrupt channel: optional synchroniser chain followed by a
// rising-edge detector on the synchronised level.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic prev;

  generate
    if (STAGES == 0) begin : g_direct
      assign level = d;
    end else begin : g_sync
      logic [STAGES-1:0] sr;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sr <= '0;
        end else begin
          sr[0] <= d;
          for (int k = 1; k < STAGES; k++) sr[k] <= sr[k-1];
        end
      end
      assign level = sr[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/exception controller: SR, Cause, EPC, PRId plus hardware
// interrupt capture and the flush request to the pipeline.
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter int                 NUM_HWINT   = 6,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_HWINT-1:0] EDGE_MASK = '0,
  parameter logic [31:0]        PRID        = 32'h2020_0707
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [31:0]          pc_m,
  input  logic                 bd_m,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hw_int,
  output logic                 int_req,
  output logic [31:0]          epc,
  output logic [2:0]           int_id,
  output logic                 exl
);

  logic [NUM_HWINT-1:0] lvl, rise, ip, ip_nx, im;
  logic                 ie, bd, int_pend, cause_wr;
  logic [4:0]           exc_q;
  logic [31:0]          epc_q;
  logic [5:0]           im6, ip6;

  for (genvar i = 0; i < NUM_HWINT; i++) begin : g_ch
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (hw_int[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  assign int_pend = ie & ~exl & |(ip & im);
  // Held low during reset so a stray exc_req cannot flush a pipeline in reset.
  assign int_req  = reset & (int_pend | (exc_req & ~exl));
  assign cause_wr = we & ~int_req & (addr == REG_CAUSE);

  always_comb begin
    ip_nx = '0;
    for (int i = 0; i < NUM_HWINT; i++) begin
      if (EDGE_MASK[i]) ip_nx[i] = rise[i] | (ip[i] & ~(cause_wr & ~wdata[CAUSE_IP_LO+i]));
      else              ip_nx[i] = lvl[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ip    <= '0;
      im    <= '0;
      ie    <= 1'b0;
      exl   <= 1'b0;
      bd    <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ip <= ip_nx;
      if (int_req) begin
        // The flushed instruction never commits, so a coincident mtc0 is lost.
        exl   <= 1'b1;
        bd    <= bd_m;
        epc_q <= word_align(bd_m ? pc_m - 32'd4 : pc_m);
        exc_q <= int_pend ? EXC_INT : exc_code;
      end else begin
        if (we && addr == REG_SR) begin
          im  <= wdata[SR_IM_LO +: NUM_HWINT];
          exl <= wdata[SR_EXL];
          ie  <= wdata[SR_IE];
        end
        if (we && addr == REG_EPC) epc_q <= word_align(wdata);
        if (eret) exl <= 1'b0;
      end
    end
  end

  always_comb begin
    int_id = 3'd7;
    for (int i = NUM_HWINT - 1; i >= 0; i--) begin
      if (ip[i] & im[i]) int_id = 3'(i);
    end
  end

  always_comb begin
    im6 = '0;
    ip6 = '0;
    im6[NUM_HWINT-1:0] = im;
    ip6[NUM_HWINT-1:0] = ip;
    case (addr)
      REG_SR:    rdata = {16'd0, im6, 8'd0, exl, ie};
      REG_CAUSE: rdata = {bd, 15'd0, ip6, 3'd0, exc_q, 2'd0};
      REG_EPC:   rdata = epc_q;
      REG_PRID:  rdata = PRID;
      default:   rdata = '0;
    endcase
  end

  assign epc = epc_q;

endmodule

// File: doc/cp0_int_ctrl.md
CP0_INT_CTRL -- requirements
Module: cp0_int_ctrl

Interface
REQ-001 Parameter NUM_HWINT, default 6, number of hardware interrupt lines; legal range 1..6.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth on hw_int; legal range 0..3.
REQ-003 Parameter EDGE_MASK, default 0, NUM_HWINT bits; bit i=1 makes channel i edge-sensitive and sticky, 0 makes it level-sensitive.
REQ-004 Parameter PRID, default 32'h2020_0707, value returned by PRId.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 we  in  1  mtc0 write strobe, M stage.
REQ-008 addr  in  5  CP0 register number for read and write.
REQ-009 wdata  in  32  mtc0 data.
REQ-010 rdata  out  32  combinational read of register addr.
REQ-011 pc_m  in  32  PC of the instruction in M.
REQ-012 bd_m  in  1  M instruction is in a branch delay slot.
REQ-013 exc_req  in  1  M instruction raised an exception.
REQ-014 exc_code  in  5  exception code, valid with exc_req.
REQ-015 eret  in  1  eret in M.
REQ-016 hw_int  in  NUM_HWINT  external interrupt lines, may be asynchronous.
REQ-017 int_req  out  1  take an interrupt or exception this cycle; flush the pipeline and redirect to the handler.
REQ-018 epc  out  32  current EPC, eret target.
REQ-019 int_id  out  3  index of the lowest-numbered pending and enabled channel; 7 when none.
REQ-020 exl  out  1  SR.EXL.

Function
REQ-021 Registers: SR(12) with IM[15:10], EXL[1], IE[0]; Cause(13) with BD[31], IP[15:10], ExcCode[6:2]; EPC(14); PRId(15). Other bits and other addresses read 0.
REQ-022 IM and IP bits at and above 10+NUM_HWINT read 0 and ignore writes.
REQ-023 Each hw_int bit passes through SYNC_STAGES flops. With SYNC_STAGES=0 it is used directly.
REQ-024 Level channel: IP[i] equals the synchronised level every cycle.
REQ-025 Edge channel: IP[i] is set on a rising edge of the synchronised input. It is cleared only by an mtc0 to Cause with wdata[10+i]=0. Set wins over a clear in the same cycle.
REQ-026 Cause writes affect only edge-channel IP bits. BD and ExcCode are read-only to software.
REQ-027 int_pend = IE & ~EXL & |(IP & IM). It is evaluated on the registered IP, so external latency is SYNC_STAGES+1 cycles from hw_int to int_req.
REQ-028 int_req = int_pend | (exc_req & ~EXL); combinational.
REQ-029 On a cycle with int_req=1, the following registers load on the next edge:
- EXL <= 1.
- BD <= bd_m.
- EPC <= {bd_m ? pc_m-4 : pc_m}[31:2],2'b00.
- ExcCode <= int_pend ? 0 : exc_code.
REQ-030 Interrupt takes priority over a simultaneous exception: ExcCode=0 and EPC uses the same pc_m.
REQ-031 exc_req while EXL=1 is ignored and causes no state change.
REQ-032 eret with int_req=0: EXL <= 0 on the next edge; epc remains stable.
REQ-033 When we and int_req coincide, the mtc0 is dropped entirely because the victim never commits.
REQ-034 When we and eret coincide, the write applies first and the eret clear of EXL wins.
REQ-035 mtc0 to EPC writes bits [31:2] and forces [1:0]=0.
REQ-036 int_id is combinational from IP & IM and ignores IE and EXL.

Reset
REQ-037 While reset is low: SR, Cause, EPC, synchroniser flops and edge detectors are 0; int_req=0, exl=0, epc=0, int_id=7.
REQ-038 Assertion mid-handler clears EXL and discards any sticky edge pending bits.

Structure
REQ-039 Package cp0_pkg holds the register numbers 12..15, the SR/Cause bit positions, and the ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
REQ-040 One sub-module int_sync (one channel: synchroniser plus rising-edge detector) is instantiated NUM_HWINT times.
REQ-041 The implementation targets 150-300 lines.

Verification
REQ-042 SR=0x0000_0401, level hw_int[0] rises, SYNC_STAGES=2: int_req high exactly 3 cycles later; EPC=pc_m; ExcCode=0; EXL=1.
REQ-043 exc_req=1, exc_code=12, bd_m=1, pc_m=0x3010: next cycle EPC=0x300C, BD=1, ExcCode=12; a second exc_req while EXL=1 leaves state unchanged.
REQ-044 Edge channel 2 pulses 1 cycle with IM[12]=0: IP[12] stays 1; mtc0 Cause with wdata=0 clears it; a set in the same cycle keeps it 1.
REQ-045 int_pend, exc_req and we all in one cycle: ExcCode=0 and the SR write is dropped. Then eret: EXL=0 next cycle and epc unchanged.
REQ-046 reset low mid-handler with a pending edge bit: all outputs 0, int_id=7; after release, no int_req until a new edge.
REQ-047 mfc0 from addr 15 returns PRID; mtc0 EPC with wdata 0x3003 reads back 0x3000.
